gated_down_counter: RTL

Loadable down-counter that consumes a start value through a valid/ready load handshake. It decrements under an `enable` gate and signals terminal count with a one-cycle `done` pulse. It pairs with the gated up-counter and counts the other way: the up-counter measures elapsed enabled cycles, and this block expires after a programmed number of enabled cycles. It is used as a programmable timeout/interval timer by control logic in the same clock domain.

---
 rtl/gated_counter_pkg.sv | 15 +
 rtl/gated_down_counter.sv | 109 ++++++++++
 2 files changed

// File: rtl/gated_counter_pkg.sv
// Shared definitions for the gated up/down counter pair.
// Holds the common state encoding used by the down-counter FSM and the
// default counter width shared by both counters.
// No ports: this file only provides localparams.
package gated_counter_pkg;

  // Default width for both the up-counter and the down-counter.
  localparam int DEFAULT_WIDTH = 4;

  // FSM state encoding, kept as plain constants so older code can use it.
  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_RUN  = 2'b01;
  localparam logic [1:0] STATE_DONE = 2'b10;

endpackage : gated_counter_pkg

// File: rtl/gated_down_counter.sv
// Loadable down-counter used as a programmable timeout / interval timer.
// A start value is taken through a valid/ready handshake while idle. The
// count then decrements on every edge where 'enable' is high. Reaching zero
// produces a one-cycle 'done' pulse. With AUTO_RELOAD set, the last accepted
// value is reloaded after each expiry, so the timer runs continuously.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset, highest priority
//   enable     - count gate, only honoured while running
//   load_valid - load request
//   load_value - start value, sampled when the handshake completes
//   load_ready - high while idle (a load can be accepted)
//   count      - remaining count (registered)
//   busy       - high while running
//   done       - one-cycle terminal-count pulse
module gated_down_counter
  import gated_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;

  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] w_nextCount;
  logic [WIDTH-1:0] w_nextReload;
  logic             w_loadAccept;

  // Loads are only accepted while idle, so load_ready doubles as the gate.
  assign w_loadAccept = load_valid && (r_state == STATE_IDLE);

  // Next-state logic for the state, count and reload registers.
  // A zero load skips RUN and expires immediately. RUN never decrements
  // from zero because it leaves on the 1 -> 0 step.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_nextReload = r_reload;
    unique case (r_state)
      STATE_IDLE: begin
        if (w_loadAccept) begin
          w_nextCount  = load_value;
          w_nextReload = load_value;
          w_nextState  = (load_value != ZERO) ? STATE_RUN : STATE_DONE;
        end
      end
      STATE_RUN: begin
        if (enable) begin
          if (r_count > ONE) begin
            w_nextCount = r_count - ONE;
          end else begin
            w_nextCount = ZERO;
            w_nextState = STATE_DONE;
          end
        end
      end
      STATE_DONE: begin
        // A zero reload value must not restart the timer, or it would
        // bounce between RUN and DONE with nothing to count.
        if ((AUTO_RELOAD != 0) && (r_reload != ZERO)) begin
          w_nextCount = r_reload;
          w_nextState = STATE_RUN;
        end else begin
          w_nextState = STATE_IDLE;
        end
      end
      default: begin
        w_nextState = STATE_IDLE;
        w_nextCount = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= STATE_IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
    end else begin
      r_state  <= w_nextState;
      r_count  <= w_nextCount;
      r_reload <= w_nextReload;
    end
  end

  // All outputs are decoded from the registered state only.
  assign load_ready = (r_state == STATE_IDLE);
  assign busy       = (r_state == STATE_RUN);
  assign done       = (r_state == STATE_DONE);
  assign count      = r_count;

endmodule : gated_down_counter
